// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-lamp sequencer.
//   state_t  : sequencer FSM state (3-bit encoding)
//   PAT_*    : 3-lamp patterns, MSB = innermost lamp (LA/RA)
package tail_light_pkg;

   localparam int unsigned LAMP_W = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L3   = 3'd3,
      R1   = 3'd4,
      R2   = 3'd5,
      R3   = 3'd6,
      HZ   = 3'd7
   } state_t;

   localparam logic [LAMP_W-1:0] PAT_OFF = 3'b000;
   localparam logic [LAMP_W-1:0] PAT_1   = 3'b100;
   localparam logic [LAMP_W-1:0] PAT_2   = 3'b110;
   localparam logic [LAMP_W-1:0] PAT_3   = 3'b111;

endpackage

// File: rtl/tail_tick_gen.sv
// Tick prescaler: free-running TICK_W-bit counter, tick on all-ones.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the counter
//   tick : 1 for one clk every 2**TICK_W cycles
module tail_tick_gen #(
   parameter int unsigned TICK_W = 24
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   logic [TICK_W-1:0] cnt;

   // Counter wraps naturally; first all-ones is 2**TICK_W cycles after reset.
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt + TICK_W'(1);
   end

   assign tick = &cnt;

endmodule

// File: rtl/tail_light_seq.sv
// Six-lamp tail-light sequencer sharing one engine between left turn,
// right turn and hazard requests. Lane-change pulses are latched so a
// started or requested sequence always completes.
// Optional build macro: TAIL_BRAKE_EN (adds brake input and overlay).
//   clk, rst      : clock, synchronous active-high reset
//   l, r, haz     : left / right / hazard requests (level)
//   brake         : brake level (TAIL_BRAKE_EN builds only)
//   LA,LB,LC      : left lamps, LA innermost
//   RA,RB,RC      : right lamps, RA innermost
//   busy          : state != IDLE
//   seq_done      : pulse on the tick that returns the FSM to IDLE
module tail_light_seq
   import tail_light_pkg::*;
#(
   parameter int unsigned TICK_W = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic l,
   input  logic r,
   input  logic haz,
`ifdef TAIL_BRAKE_EN
   input  logic brake,
`endif
   output logic LA,
   output logic LB,
   output logic LC,
   output logic RA,
   output logic RB,
   output logic RC,
   output logic busy,
   output logic seq_done
);

   logic              tick;
   state_t            state_q;
   state_t            state_d;
   logic              pend_l;
   logic              pend_r;
   logic              req_l;
   logic              req_r;
   logic              enter_l;
   logic              enter_r;
   logic [LAMP_W-1:0] left_lamps;
   logic [LAMP_W-1:0] right_lamps;

   tail_tick_gen #(.TICK_W(TICK_W)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign req_l = l | pend_l;
   assign req_r = r | pend_r;

   // Hazard entry serves both sides, so it clears both latches.
   assign enter_l = tick & ((state_d == L1) | (state_d == HZ));
   assign enter_r = tick & ((state_d == R1) | (state_d == HZ));

   // State register; advances only on ticks.
   always_ff @(posedge clk) begin
      if (rst)       state_q <= IDLE;
      else if (tick) state_q <= state_d;
   end

   // Pending latches; clearing on entry wins over a same-edge request.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_l <= 1'b0;
         pend_r <= 1'b0;
      end else begin
         pend_l <= enter_l ? 1'b0 : (pend_l | l);
         pend_r <= enter_r ? 1'b0 : (pend_r | r);
      end
   end

   // Next state and Moore output decode.
   always_comb begin
      state_d     = state_q;
      left_lamps  = PAT_OFF;
      right_lamps = PAT_OFF;
      busy        = 1'b1;
      seq_done    = 1'b0;

      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (haz | (req_l & req_r)) state_d = HZ;
            else if (req_l)            state_d = L1;
            else if (req_r)            state_d = R1;
         end
         L1: begin left_lamps = PAT_1;  state_d = L2;   end
         L2: begin left_lamps = PAT_2;  state_d = L3;   end
         L3: begin left_lamps = PAT_3;  state_d = IDLE; end
         R1: begin right_lamps = PAT_1; state_d = R2;   end
         R2: begin right_lamps = PAT_2; state_d = R3;   end
         R3: begin right_lamps = PAT_3; state_d = IDLE; end
         HZ: begin
            left_lamps  = PAT_3;
            right_lamps = PAT_3;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

`ifdef TAIL_BRAKE_EN
      // Brake lights every lamp not owned by the active sequence; hazard wins.
      if (brake) begin
         case (state_q)
            IDLE: begin
               left_lamps  = PAT_3;
               right_lamps = PAT_3;
            end
            L1, L2, L3: right_lamps = PAT_3;
            R1, R2, R3: left_lamps  = PAT_3;
            default: ;
         endcase
      end
`endif

      seq_done = tick & ((state_q == L3) | (state_q == R3) | (state_q == HZ));
   end

   assign {LA, LB, LC} = left_lamps;
   assign {RA, RB, RC} = right_lamps;

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq with TICK_W=2 (tick every 4th clk).
// Cycle 1 is the first clk period after the last reset edge.
`timescale 1ns/1ps
module tb_tail_light_seq;

   logic clk;
   logic rst;
   logic l;
   logic r;
   logic haz;
`ifdef TAIL_BRAKE_EN
   logic brake;
`endif
   logic LA, LB, LC, RA, RB, RC;
   logic busy;
   logic seq_done;
   logic [5:0] lamps;

   int n_vec;
   int n_mis;
   int cyc;

   tail_light_seq #(.TICK_W(2)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .l        (l),
      .r        (r),
      .haz      (haz),
`ifdef TAIL_BRAKE_EN
      .brake    (brake),
`endif
      .LA       (LA),
      .LB       (LB),
      .LC       (LC),
      .RA       (RA),
      .RB       (RB),
      .RC       (RC),
      .busy     (busy),
      .seq_done (seq_done)
   );

   assign lamps = {LA, LB, LC, RA, RB, RC};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Advance one clk; sample/drive 1 ns after the edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) next_cycle();
   endtask

   // Three reset cycles; on return we are in cycle 1.
   task automatic do_reset();
      rst = 1'b1;
      l   = 1'b0;
      r   = 1'b0;
      haz = 1'b0;
`ifdef TAIL_BRAKE_EN
      brake = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 1;
   endtask

   initial begin
      n_vec = 0;
      n_mis = 0;
      cyc   = 0;

      // 1. Reset state and first tick position
      do_reset();
      check("rst_lamps", 8'(lamps), 8'h00);
      check("rst_busy", 8'(busy), 8'h0);
      goto(3);
      check("rst_tick_c3", 8'(u_dut.tick), 8'h0);
      goto(4);
      check("rst_tick_c4", 8'(u_dut.tick), 8'h1);
      goto(8);
      check("idle_stays_dark", 8'(lamps), 8'h00);

      // 2. Left sequence with l held
      do_reset();
      l = 1'b1;
      goto(4);
      check("left_c4", 8'(lamps), 8'h00);
      goto(5);
      check("left_c5", 8'(lamps), 8'b100_000);
      check("left_busy", 8'(busy), 8'h1);
      goto(9);
      check("left_c9", 8'(lamps), 8'b110_000);
      goto(13);
      check("left_c13", 8'(lamps), 8'b111_000);
      goto(15);
      check("left_done_c15", 8'(seq_done), 8'h0);
      goto(16);
      check("left_done_c16", 8'(seq_done), 8'h1);
      goto(17);
      check("left_c17", 8'(lamps), 8'b000_000);
      check("left_busy_c17", 8'(busy), 8'h0);
      check("left_done_c17", 8'(seq_done), 8'h0);
      goto(20);
      check("left_dark_c20", 8'(lamps), 8'b000_000);
      goto(21);
      check("left_c21", 8'(lamps), 8'b100_000);
      l = 1'b0;

      // 3. Lane-change pulse on r
      do_reset();
      goto(2);
      r = 1'b1;
      goto(3);
      r = 1'b0;
      goto(5);
      check("pulse_c5", 8'(lamps), 8'b000_100);
      goto(9);
      check("pulse_c9", 8'(lamps), 8'b000_110);
      goto(13);
      check("pulse_c13", 8'(lamps), 8'b000_111);
      goto(16);
      check("pulse_done_c16", 8'(seq_done), 8'h1);
      goto(17);
      check("pulse_c17", 8'(lamps), 8'b000_000);
      goto(21);
      check("pulse_c21", 8'(lamps), 8'b000_000);
      goto(25);
      check("pulse_c25", 8'(lamps), 8'b000_000);
      check("pulse_busy_c25", 8'(busy), 8'h0);

      // 4. r pulse during L2 is held until IDLE, then HZ
      do_reset();
      l = 1'b1;
      goto(10);
      r = 1'b1;
      goto(11);
      r = 1'b0;
      goto(13);
      check("mid_c13", 8'(lamps), 8'b111_000);
      goto(17);
      check("mid_c17", 8'(lamps), 8'b000_000);
      goto(21);
      check("mid_hz_c21", 8'(lamps), 8'b111_111);
      goto(24);
      check("mid_done_c24", 8'(seq_done), 8'h1);
      goto(25);
      check("mid_c25", 8'(lamps), 8'b000_000);
      goto(29);
      check("mid_c29", 8'(lamps), 8'b100_000);
      l = 1'b0;

      // 5. Hazard has priority over l; blinks at tick rate
      do_reset();
      l   = 1'b1;
      haz = 1'b1;
      goto(5);
      check("haz_c5", 8'(lamps), 8'b111_111);
      goto(8);
      check("haz_done_c8", 8'(seq_done), 8'h1);
      goto(9);
      check("haz_c9", 8'(lamps), 8'b000_000);
      goto(13);
      check("haz_c13", 8'(lamps), 8'b111_111);
      haz = 1'b0;
      goto(17);
      check("haz_c17", 8'(lamps), 8'b000_000);
      goto(21);
      check("haz_left_c21", 8'(lamps), 8'b100_000);
      l = 1'b0;

      // 6. Reset during R2, then tick realigned to release
      do_reset();
      r = 1'b1;
      goto(2);
      r = 1'b0;
      goto(9);
      check("rmid_c9", 8'(lamps), 8'b000_110);
      goto(10);
      rst = 1'b1;
      goto(11);
      check("rmid_lamps_c11", 8'(lamps), 8'h00);
      check("rmid_busy_c11", 8'(busy), 8'h0);
      rst = 1'b0;
      goto(12);
      r = 1'b1;
      goto(13);
      r = 1'b0;
      check("rmid_tick_c13", 8'(u_dut.tick), 8'h0);
      goto(14);
      check("rmid_tick_c14", 8'(u_dut.tick), 8'h1);
      check("rmid_c14", 8'(lamps), 8'h00);
      goto(15);
      check("rmid_c15", 8'(lamps), 8'b000_100);

`ifdef TAIL_BRAKE_EN
      // Brake overlay in IDLE and during a left sequence
      do_reset();
      brake = 1'b1;
      goto(2);
      check("brake_idle", 8'(lamps), 8'b111_111);
      l = 1'b1;
      goto(9);
      check("brake_l2", 8'(lamps), 8'b110_111);
      l     = 1'b0;
      brake = 1'b0;
      goto(10);
      check("brake_off_l2", 8'(lamps), 8'b110_000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
